axil_master: RTL

Single-outstanding AXI4-Lite master bridge: accepts one simple request (read or write) from a core-side load/store port and turns it into a full AXI4-Lite transaction on the system bus. It drives the master side of the AW/W/B/AR/R channels that the on-chip RAM and peripheral slaves respond to, and returns read data or error status to the requester. One transaction is in flight at a time; no reordering, no bursts.

---
 rtl/axil_master.sv | 104 ++++++++++
 1 files changed

// File: rtl/axil_master.sv
`timescale 1ns/1ps
// axil_master: single-outstanding bridge from a simple load/store request port to an AXI4-Lite master.
module axil_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_wstrb_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;
  state_t state, state_nx;
  logic aw_done, w_done, aw_hs, w_hs;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic unused_resp;
  assign unused_resp = ^{m_axi_bresp[0], m_axi_rresp[0]};
  // every bus-facing output is decoded from state/flags, so AXI inputs never reach AXI outputs
  assign req_ready_o   = state == IDLE;
  assign m_axi_awvalid = state == WADDR && !aw_done;
  assign m_axi_wvalid  = state == WADDR && !w_done;
  assign m_axi_bready  = state == WRESP;
  assign m_axi_arvalid = state == RADDR;
  assign m_axi_rready  = state == RDATA;
  assign rsp_valid_o   = state == RESP;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid_i ? (req_we_i ? WADDR : RADDR) : IDLE;
      WADDR:   state_nx = ((aw_done | aw_hs) & (w_done | w_hs)) ? WRESP : WADDR;
      WRESP:   state_nx = m_axi_bvalid ? RESP : WRESP;
      RADDR:   state_nx = m_axi_arready ? RDATA : RADDR;
      RDATA:   state_nx = m_axi_rvalid ? RESP : RDATA;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid_i) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        wstrb_q <= req_wstrb_i;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (state == WRESP && m_axi_bvalid) begin
        rsp_err_o   <= m_axi_bresp[1];
        rsp_rdata_o <= '0;
      end
      if (state == RDATA && m_axi_rvalid) begin
        rsp_err_o   <= m_axi_rresp[1];
        rsp_rdata_o <= m_axi_rresp[1] ? '0 : m_axi_rdata;
      end
    end
endmodule
